// File: rtl/fifo_bank_sync.sv
// Bank of CHANNELS independent synchronous FIFOs on one clock, with per-channel
// flags, free-location count, sticky error flags, flush and show-ahead/registered read.

module fifo_bank_chan #(
    parameter int WIDTH      = 56,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 2,
    parameter int SHOW_AHEAD = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   empty_locs,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_acc;
    logic             wr_acc;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign empty_locs  = CW'(DEPTH) - count;
    assign almost_full = (empty_locs <= CW'(AF_THRESH));

    // A full channel still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            count <= count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Set wins over clear; flush suppresses the set conditions only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc & ~flush) overflow <= 1'b1;
            else if (clr_err)             overflow <= 1'b0;
            if (rd_en & empty & ~flush)   underflow <= 1'b1;
            else if (clr_err)             underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= wr_data;
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            assign rd_valid = ~empty;
            assign rd_data  = empty ? '0 : mem[rptr];
        end else begin : g_registered
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            // One-cycle pulse per accepted read; zero otherwise (flush blocks rd_acc).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    data_q  <= rd_acc ? mem[rptr] : '0;
                end
            end

            assign rd_valid = valid_q;
            assign rd_data  = data_q;
        end
    endgenerate
endmodule

module fifo_bank_sync #(
    parameter int WIDTH      = 56,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 3,
    parameter int AF_THRESH  = 2,
    parameter int SHOW_AHEAD = 1
) (
    input  logic                                apb_clk,
    input  logic                                apb_rst,
    input  logic [CHANNELS-1:0]                 wr_en,
    input  logic [CHANNELS*WIDTH-1:0]           wr_data,
    input  logic [CHANNELS-1:0]                 rd_en,
    input  logic [CHANNELS-1:0]                 flush,
    input  logic [CHANNELS-1:0]                 clr_err,
    output logic [CHANNELS*WIDTH-1:0]           rd_data,
    output logic [CHANNELS-1:0]                 rd_valid,
    output logic [CHANNELS-1:0]                 empty,
    output logic [CHANNELS-1:0]                 full,
    output logic [CHANNELS-1:0]                 almost_full,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] empty_locs,
    output logic [CHANNELS-1:0]                 overflow,
    output logic [CHANNELS-1:0]                 underflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            fifo_bank_chan #(
                .WIDTH      (WIDTH),
                .DEPTH      (DEPTH),
                .AF_THRESH  (AF_THRESH),
                .SHOW_AHEAD (SHOW_AHEAD)
            ) u_ch (
                .clk         (apb_clk),
                .rst_n       (apb_rst),
                .wr_en       (wr_en[c]),
                .wr_data     (wr_data[c*WIDTH +: WIDTH]),
                .rd_en       (rd_en[c]),
                .flush       (flush[c]),
                .clr_err     (clr_err[c]),
                .rd_data     (rd_data[c*WIDTH +: WIDTH]),
                .rd_valid    (rd_valid[c]),
                .empty       (empty[c]),
                .full        (full[c]),
                .almost_full (almost_full[c]),
                .empty_locs  (empty_locs[c*CW +: CW]),
                .overflow    (overflow[c]),
                .underflow   (underflow[c])
            );
        end
    endgenerate
endmodule

// File: doc/fifo_bank_sync.md
Name: fifo_bank_sync

Overview:
Parametrised bank of CHANNELS independent synchronous FIFOs sharing one clock, for the APB-side command/response buffering of the UART-to-APB bridge. Each channel provides full/empty/almost-full flags, a free-location count and sticky overflow/underflow error flags. Each channel also has a synchronous flush. Read data is zeroed whenever no valid word is presented. A mode parameter selects show-ahead or registered read timing.

Parameters:
WIDTH, 56, data width per channel in bits
DEPTH, 16, entries per channel; power of 2, >= 4
CHANNELS, 3, number of independent FIFOs
AF_THRESH, 2, almost_full asserts when free locations <= AF_THRESH; range 1..DEPTH-1
SHOW_AHEAD, 1, 1 = head word presented combinationally; 0 = registered read with one-cycle latency

Ports:
apb_clk  in  1  single clock, rising edge
apb_rst  in  1  asynchronous reset, active-low
wr_en  in  CHANNELS  per-channel write request
wr_data  in  CHANNELS*WIDTH  packed; channel c occupies bits [c*WIDTH +: WIDTH]
rd_en  in  CHANNELS  per-channel read request
flush  in  CHANNELS  per-channel synchronous flush
clr_err  in  CHANNELS  clears the sticky error flags of the channel
rd_data  out  CHANNELS*WIDTH  packed read data
rd_valid  out  CHANNELS  rd_data of the channel is valid
empty  out  CHANNELS  channel holds 0 words
full  out  CHANNELS  channel holds DEPTH words
almost_full  out  CHANNELS  free locations <= AF_THRESH
empty_locs  out  CHANNELS*CW  free locations, 0..DEPTH; CW = $clog2(DEPTH)+1
overflow  out  CHANNELS  sticky: a write was rejected
underflow  out  CHANNELS  sticky: a read was rejected

Behaviour:
- Channels are fully independent. Each channel has a write pointer, a read pointer ($clog2(DEPTH) bits, natural wrap from DEPTH-1 to 0) and a count register (CW bits).
- Reset (apb_rst=0, asynchronous) values:
  - pointers=0, count=0
  - empty=1, full=0, almost_full=0
  - empty_locs=DEPTH
  - overflow=0, underflow=0
  - rd_data=0, rd_valid=0
  - Memory contents are not reset.
- Flags are decoded from the registered count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_full = (DEPTH-count <= AF_THRESH)
  - empty_locs = DEPTH-count
- Read accepted: rd_acc = rd_en & !empty.
- Write accepted: wr_acc = wr_en & (!full | rd_acc).
  - A write to a full channel succeeds when a read is accepted in the same cycle; the read returns the old head word.
  - A write into an empty channel is not readable until the next cycle.
- Per-cycle update: count += wr_acc - rd_acc. wr_acc writes mem[wptr] and increments wptr. rd_acc increments rptr.
- Error flags:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & empty.
  - clr_err clears both flags; a set condition in the same cycle wins over clr_err.
- flush has top priority:
  - Pointers and count return to 0 next cycle.
  - wr_en/rd_en in the flush cycle are ignored and do not set error flags.
  - Error flags are unaffected by flush.
  - With SHOW_AHEAD=0, rd_valid/rd_data are cleared next cycle.
- SHOW_AHEAD=1:
  - rd_valid = !empty.
  - rd_data = empty ? 0 : mem[rptr], combinational from the registered pointer.
  - rd_en acts as a pop acknowledge.
- SHOW_AHEAD=0:
  - On rd_acc, the next cycle gives rd_data = mem[rptr] (value before increment) and rd_valid=1.
  - In any cycle without rd_acc, the next cycle gives rd_data=0 and rd_valid=0. Output is a one-cycle pulse per accepted read.
  - Back-to-back reads produce one word per cycle.
- No combinational path from wr_en/wr_data to any output. With SHOW_AHEAD=1, rd_data depends on rd_en only through registered state.

Test Plan:
- Reset: apb_rst low mid-traffic -> all channels empty=1, full=0, empty_locs=16, rd_data=0, rd_valid=0, overflow=0, underflow=0 immediately (asynchronous).
- Fill/drain ch1: 16 writes of 0x1..0x10 -> almost_full=1 when empty_locs=2, full=1 after the 16th write. 17th write -> overflow[1]=1, count stays 16. Drain 16 reads -> 0x1..0x10 in order, then empty=1 and rd_data=0.
- Full with simultaneous read and write on ch0: write 0xAA while reading -> read returns the old head, count stays 16, overflow stays 0. 0xAA emerges after the remaining 15 words.
- Wrap-around: 40 interleaved writes/reads on ch2 at count 0..3 -> data order preserved across pointer wrap, empty_locs correct every cycle.
- Underflow and flush: rd_en on empty ch0 -> underflow[0]=1. clr_err -> 0; clr_err asserted together with another empty read -> stays 1. Flush ch1 holding 5 words while writing -> empty=1 and empty_locs=16 next cycle, no overflow, ch0/ch2 counts unchanged.
- SHOW_AHEAD=0 build: write 0x55, 0x66; rd_en for 2 cycles -> rd_valid high for exactly 2 cycles starting one cycle later, data 0x55 then 0x66, then rd_data=0.
